// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared encodings for the iterative multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiply path).
package ex_muldiv_unit_pkg;
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  // MULT and DIV (even encodings) are the signed variants
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_mul(input logic [1:0] op);
    return ~op[1];
  endfunction
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage <-> multiply/divide unit signal bundle.
interface ex_muldiv_unit_if;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mt_hi;
  logic        mt_lo;
  logic        mf_sel;
  logic        flush;
  logic        stall;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_start, md_op, op_a, op_b, mt_hi, mt_lo, mf_sel, flush,
    input  stall, mf_data, hi, lo
  );

  modport slave (
    input  md_start, md_op, op_a, op_b, mt_hi, mt_lo, mf_sel, flush,
    output stall, mf_data, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit_sign_fix.sv
// muldiv_sign_fix: operand magnitude conversion at start and two's-complement
// sign correction of the raw unsigned result in the FIX stage.
module muldiv_sign_fix (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_signed,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        a_neg,
  output logic        b_neg,
  input  logic        is_mul,
  input  logic        neg_lo,
  input  logic        neg_hi,
  input  logic [63:0] acc,
  input  logic [31:0] rem,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);
  logic [63:0] prod;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign a_neg = is_signed & op_a[31];
  assign b_neg = is_signed & op_b[31];
  assign a_mag = a_neg ? (~op_a + 32'd1) : op_a;
  assign b_mag = b_neg ? (~op_b + 32'd1) : op_b;

  // multiply negates the full 64-bit product; divide negates each half on its own sign
  assign prod     = neg_lo ? (~acc + 64'd1) : acc;
  assign quot_fix = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix  = neg_hi ? (~rem + 32'd1) : rem;

  assign res_hi = is_mul ? prod[63:32] : rem_fix;
  assign res_lo = is_mul ? prod[31:0]  : quot_fix;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with pipeline stall.
// Optional build macro: MULDIV_FAST_MUL_EN (multiply in one cycle, IDLE->FIX).
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
(
  input logic               clk,
  input logic               reset,
  ex_muldiv_unit_if.slave   bus
);
  logic [1:0]  state;
  logic [4:0]  count;
  logic        is_mul;
  logic        div_zero;
  logic        neg_lo;
  logic        neg_hi;
  logic [31:0] a_orig;
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic [63:0] acc;       // mul: {partial product, multiplier}; div: {0, dividend->quotient}
  logic [32:0] rem;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] a_mag, b_mag, res_hi, res_lo;
  logic        a_neg, b_neg, start_mul;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;

  assign start_mul = op_is_mul(bus.md_op);

  muldiv_sign_fix u_sign (
    .op_a     (bus.op_a),
    .op_b     (bus.op_b),
    .is_signed(op_is_signed(bus.md_op)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .a_neg    (a_neg),
    .b_neg    (b_neg),
    .is_mul   (is_mul),
    .neg_lo   (neg_lo),
    .neg_hi   (neg_hi),
    .acc      (acc),
    .rem      (rem[31:0]),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  // one shift-add step: add multiplicand to the upper half when multiplier LSB is set
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  // one restoring step: bring in the next dividend bit and trial-subtract the divisor
  assign div_shift = {rem[31:0], acc[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};

  assign bus.stall   = (state != ST_IDLE);
  assign bus.mf_data = bus.mf_sel ? hi_q : lo_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

  // FSM, iteration datapath and HI/LO architectural registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= 5'd0;
      is_mul   <= 1'b0;
      div_zero <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      a_orig   <= 32'd0;
      opnd     <= 32'd0;
      acc      <= 64'd0;
      rem      <= 33'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.md_start && !bus.flush) begin
            is_mul   <= start_mul;
            div_zero <= !start_mul && (bus.op_b == 32'd0);
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= start_mul ? (a_neg ^ b_neg) : a_neg;
            a_orig   <= bus.op_a;
            count    <= 5'd0;
            rem      <= 33'd0;
            opnd     <= start_mul ? a_mag : b_mag;
`ifdef MULDIV_FAST_MUL_EN
            if (start_mul) begin
              acc   <= {32'd0, a_mag} * {32'd0, b_mag};
              state <= ST_FIX;
            end else begin
              acc   <= {32'd0, a_mag};
              state <= ST_CALC;
            end
`else
            acc   <= {32'd0, start_mul ? b_mag : a_mag};
            state <= ST_CALC;
`endif
          end else if (!bus.md_start && !bus.flush) begin
            // a squashed MTHI/MTLO must not retire, so flush also blocks it
            if (bus.mt_hi) hi_q <= bus.op_a;
            if (bus.mt_lo) lo_q <= bus.op_a;
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else begin
            if (is_mul) begin
              acc <= {mul_sum, acc[31:1]};
            end else begin
              rem <= div_diff[33] ? div_shift : div_diff[32:0];
              acc <= {32'd0, acc[30:0], ~div_diff[33]};
            end
            count <= count + 5'd1;
            if (count == 5'd31) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!bus.flush) begin
            hi_q <= div_zero ? a_orig : res_hi;
            lo_q <= div_zero ? DIV_BY_ZERO_LO : res_lo;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
